// File: rtl/vec_pipe_stage.sv
// Valid/ready pipeline register with a 2-entry skid buffer, synchronous flush,
// bubble gating of the write/read enables and optional negedge output retiming.
module vec_pipe_stage #(
  parameter int PC_W    = 16,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 23,
  parameter int KEY_W   = 2,
  parameter int LANE_W  = 5,
  parameter bit NEG_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [ADDR_W-1:0] dir_mem_in,
  input  logic [DATA_W-1:0] dato_vectA_in,
  input  logic              escritura_regV_in,
  input  logic              lectura_dmem_in,
  input  logic              escritura_dmem_in,
  input  logic              select_wb_in,
  input  logic [KEY_W-1:0]  mux_key_in,
  input  logic [LANE_W-1:0] lane_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [ADDR_W-1:0] dir_mem_out,
  output logic [DATA_W-1:0] dato_vectA_out,
  output logic              escritura_regV_out,
  output logic              lectura_dmem_out,
  output logic              escritura_dmem_out,
  output logic              select_wb_out,
  output logic [KEY_W-1:0]  mux_key_out,
  output logic [LANE_W-1:0] lane_out,
  output logic [1:0]        occupancy
);
  localparam int BW = PC_W + ADDR_W + DATA_W + 4 + KEY_W + LANE_W;

  logic [BW-1:0] w_in, r_m, r_s, w_o;
  logic          r_m_valid, r_s_valid, w_o_valid;
  logic          w_accept, w_m_load;
  logic          w_regv, w_rd, w_wr;

  assign w_in = {pc_in, dir_mem_in, dato_vectA_in, escritura_regV_in,
                 lectura_dmem_in, escritura_dmem_in, select_wb_in, mux_key_in, lane_in};

  // in_ready depends only on registered state, never on out_ready
  assign in_ready  = !r_s_valid;
  assign w_accept  = in_valid && !r_s_valid;
  assign w_m_load  = !r_m_valid || out_ready;
  assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_s       <= '0;
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_m_load) begin
      // skid entry always drains ahead of new input to keep arrival order
      if (r_s_valid) begin
        r_m       <= r_s;
        r_m_valid <= 1'b1;
        r_s_valid <= 1'b0;
      end else if (w_accept) begin
        r_m       <= w_in;
        r_m_valid <= 1'b1;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_s       <= w_in;
      r_s_valid <= 1'b1;
    end
  end

  generate
    if (NEG_OUT) begin : g_neg
      logic [BW-1:0] r_o;
      logic          r_o_valid;
      always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_o       <= '0;
          r_o_valid <= 1'b0;
        end else begin
          r_o       <= r_m;
          r_o_valid <= r_m_valid;
        end
      end
      assign w_o       = r_o;
      assign w_o_valid = r_o_valid;
    end else begin : g_pos
      assign w_o       = r_m;
      assign w_o_valid = r_m_valid;
    end
  endgenerate

  assign {pc_out, dir_mem_out, dato_vectA_out, w_regv, w_rd, w_wr,
          select_wb_out, mux_key_out, lane_out} = w_o;

  assign out_valid          = w_o_valid;
  assign escritura_regV_out = w_regv && w_o_valid;
  assign lectura_dmem_out   = w_rd   && w_o_valid;
  assign escritura_dmem_out = w_wr   && w_o_valid;
endmodule

// File: doc/vec_pipe_stage.md
Name: vec_pipe_stage

Overview:
- Parametrised pipeline register for the vector processor, placed between decode and memory/execute and reusable at later stage boundaries.
- Replaces the fixed always-advance stage register with:
  - a valid/ready handshake,
  - a 2-entry skid buffer, so backpressure is absorbed without combinational ready paths,
  - synchronous flush,
  - write-enable gating on bubbles,
  - an optional negedge output retiming mode.

Parameters:
PC_W, 16, program counter width
ADDR_W, 15, data-memory address width
DATA_W, 23, vector operand A width
KEY_W, 2, mux key width
LANE_W, 5, lane index width
NEG_OUT, 0, 1 = output registers retimed on the falling edge of clk; 0 = outputs driven straight from posedge state

Ports:
clk  in  1  stage clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  upstream holds a valid bundle
in_ready  out  1  stage can accept a bundle this cycle
flush  in  1  synchronous kill of all held bundles
pc_in  in  PC_W  program counter
dir_mem_in  in  ADDR_W  data-memory address
dato_vectA_in  in  DATA_W  vector operand A
escritura_regV_in  in  1  vector register write enable
lectura_dmem_in  in  1  data-memory read enable
escritura_dmem_in  in  1  data-memory write enable
select_wb_in  in  1  writeback source select
mux_key_in  in  KEY_W  mux key
lane_in  in  LANE_W  lane index
out_valid  out  1  downstream bundle valid
out_ready  in  1  downstream accepts the bundle
pc_out, dir_mem_out, dato_vectA_out, escritura_regV_out, lectura_dmem_out, escritura_dmem_out, select_wb_out, mux_key_out, lane_out  out  matching widths  registered bundle
occupancy  out  2  number of held bundles, 0..2

Behaviour:
- Storage: main register M (m_valid) drives the outputs; skid register S (s_valid) holds overflow. All state updates on posedge clk.
- in_ready = !s_valid. It is a register output only, with no combinational path from out_ready.
- Accept: occurs when in_valid && in_ready. Consume: occurs when m_valid && out_ready.
- M load rule, applied when !m_valid || out_ready:
  - if s_valid: M <= S and s_valid <= 0;
  - else if accept: M <= input;
  - m_valid follows which source was loaded (0 if neither).
- S load rule: when accept occurs while M is held (m_valid && !out_ready), S <= input and s_valid <= 1.
- Accept with s_valid=1 cannot occur, because in_ready is 0.
- Latency: 1 posedge from accept to out_valid when the stage is empty. Throughput is 1 bundle per cycle with out_ready held high.
- Order: bundles leave in strict arrival order. S always drains before new input reaches M.
- occupancy = m_valid + s_valid.
- flush = 1 at a posedge:
  - m_valid <= 0 and s_valid <= 0;
  - any input offered that cycle is dropped, even if in_ready was 1;
  - flush takes priority over every load rule.
- Bubble gating: escritura_regV_out, lectura_dmem_out and escritura_dmem_out are forced to 0 whenever out_valid = 0.
- Payload outputs not gated by bubble gating (pc_out, dir_mem_out, dato_vectA_out, select_wb_out, mux_key_out, lane_out) retain the last loaded value when out_valid = 0.
- NEG_OUT = 1:
  - all outputs except in_ready and occupancy are copied from M/m_valid on negedge clk, adding half a cycle;
  - out_ready is still sampled at posedge against the internal m_valid;
  - the downstream stage samples the outputs at the following posedge.
- Reset (rst_n = 0), immediate and asynchronous:
  - m_valid = s_valid = 0;
  - all data fields and outputs = 0, including the negedge copies;
  - occupancy = 0; in_ready = 1.
- Reset mid-transfer discards both held bundles. There is no partial state after rst_n rises.

Test Plan:
- Reset, then in_valid=1, pc_in=16'h0010, out_ready=1 → at the next posedge out_valid=1 and pc_out=16'h0010; in_ready stays 1.
- Stream pc_in = 1, 2, 3, 4 on back-to-back cycles with out_ready=1 → pc_out shows 1, 2, 3, 4 on consecutive cycles with no gaps; occupancy stays at 1.
- Backpressure:
  - Stimulus: out_ready=0 while pc_in 5 and then 6 are offered.
  - M holds 5 and S holds 6; occupancy=2 and in_ready=0.
  - A third offer of pc_in 7 is not accepted.
  - Raise out_ready → outputs 5, 6, 7 in order; in_ready returns to 1 one cycle after S drains.
- flush with occupancy=2 and in_valid=1 (pc_in=9) → next cycle out_valid=0, occupancy=0, escritura_dmem_out=0; pc 9 never appears at the output.
- Bubble gating: load escritura_regV_in=1, then drain with no new input → escritura_regV_out drops to 0 when out_valid drops, while pc_out holds its value.
- NEG_OUT=1:
  - pc_out changes on the falling edge after the load posedge.
  - Assert rst_n=0 between edges → all outputs go to 0 at once, without waiting for a clock.
